// File: rtl/ultrasonic_echo_responder_if.sv
// Trigger/echo link between a ranging-sensor driver (master) and the
// emulated HC-SR04 sensor (slave).
interface ultrasonic_echo_responder_if;
  logic       trig;
  logic [7:0] distance_cm;
  logic       echo;
  logic       busy;
  logic       short_trig;

  modport master (
    output trig,
    output distance_cm,
    input  echo,
    input  busy,
    input  short_trig
  );

  modport slave (
    input  trig,
    input  distance_cm,
    output echo,
    output busy,
    output short_trig
  );
endinterface

// File: rtl/ultrasonic_echo_responder.sv
// HC-SR04 sensor-side emulator: accepts a trigger pulse and replies with an
// echo pulse whose width encodes distance_cm (CYCLES_PER_CM cycles per cm).
// Optional feature macro: ECHO_MAX_RANGE_EN -- when defined, distances of 0
// or above MAX_CM report "no object" with a TIMEOUT_CYCLES-wide echo.
module ultrasonic_echo_responder #(
  parameter int TRIG_MIN_CYCLES = 500,
  parameter int BURST_CYCLES    = 10000,
  parameter int CYCLES_PER_CM   = 2900,
  parameter int MAX_CM          = 200,
  parameter int TIMEOUT_CYCLES  = 1900000,
  parameter int HOLDOFF_CYCLES  = 500000
) (
  input logic                         clk,
  input logic                         rst,
  ultrasonic_echo_responder_if.slave  bus
);

  // Every timing constant has to fit the 24-bit counters; catch bad
  // overrides at elaboration rather than in the field.
  generate
    if (TRIG_MIN_CYCLES < 1 || TRIG_MIN_CYCLES >= 2**24 ||
        BURST_CYCLES    < 1 || BURST_CYCLES    >= 2**24 ||
        CYCLES_PER_CM   < 1 || CYCLES_PER_CM   >= 2**24 ||
        MAX_CM          < 0 || MAX_CM          >= 2**24 ||
        TIMEOUT_CYCLES  < 1 || TIMEOUT_CYCLES  >= 2**24 ||
        HOLDOFF_CYCLES  < 1 || HOLDOFF_CYCLES  >= 2**24) begin : g_param_range
      $error("ultrasonic_echo_responder: timing parameter outside 1..2^24-1");
    end
  endgenerate

  localparam logic [23:0] TRIG_MIN     = 24'(TRIG_MIN_CYCLES);
  localparam logic [23:0] BURST_LAST   = 24'(BURST_CYCLES - 1);
  localparam logic [23:0] HOLDOFF_LAST = 24'(HOLDOFF_CYCLES - 1);
  localparam logic [23:0] CPC          = 24'(CYCLES_PER_CM);

  typedef enum logic [2:0] {
    IDLE,
    TRIG_HIGH,
    BURST,
    ECHO,
    HOLDOFF
  } state_t;

  state_t      state_reg, state_next;
  logic        sync1_reg, trig_s_reg, trig_prev_reg;
  logic        trig_rise;
  logic [23:0] trig_cnt_reg, trig_cnt_next;
  logic [23:0] cnt_reg, cnt_next;
  logic [7:0]  dist_q_reg;
  logic        dist_latch;
  logic [23:0] width_q_reg, width_calc;
  logic        echo_reg, busy_reg, short_trig_reg, short_trig_next;

  // Two-flop synchroniser for the asynchronous trigger pin plus an edge
  // history flop. The history keeps tracking during HOLDOFF so a trigger held
  // across HOLDOFF exit never looks like a fresh rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg     <= 1'b0;
      trig_s_reg    <= 1'b0;
      trig_prev_reg <= 1'b0;
    end else begin
      sync1_reg     <= bus.trig;
      trig_s_reg    <= sync1_reg;
      trig_prev_reg <= trig_s_reg;
    end
  end

  assign trig_rise = trig_s_reg & ~trig_prev_reg;

  // Echo width from the latched distance; a zero distance reads as 1 cm
  // (or as no object when the range check is built).
`ifdef ECHO_MAX_RANGE_EN
  localparam logic [23:0] MAX_RANGE = 24'(MAX_CM);
  localparam logic [23:0] TIMEOUT   = 24'(TIMEOUT_CYCLES);

  always_comb begin
    width_calc = 24'(dist_q_reg) * CPC;
    if (dist_q_reg == 8'd0 || 24'(dist_q_reg) > MAX_RANGE) begin
      width_calc = TIMEOUT;
    end
  end
`else
  logic [7:0] dist_eff;

  always_comb begin
    dist_eff   = (dist_q_reg == 8'd0) ? 8'd1 : dist_q_reg;
    width_calc = 24'(dist_eff) * CPC;
  end
`endif

  // Next-state and counter logic; one shared counter times BURST, ECHO and
  // HOLDOFF since only one of them is active at a time.
  always_comb begin
    state_next      = state_reg;
    trig_cnt_next   = trig_cnt_reg;
    cnt_next        = cnt_reg;
    short_trig_next = 1'b0;
    dist_latch      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (trig_rise) begin
          state_next    = TRIG_HIGH;
          trig_cnt_next = 24'd1;
        end
      end
      TRIG_HIGH: begin
        if (trig_s_reg) begin
          if (trig_cnt_reg < TRIG_MIN) begin
            trig_cnt_next = trig_cnt_reg + 24'd1;
          end
        end else if (trig_cnt_reg >= TRIG_MIN) begin
          state_next = BURST;
          cnt_next   = 24'd0;
          dist_latch = 1'b1;
        end else begin
          state_next      = IDLE;
          short_trig_next = 1'b1;
        end
      end
      BURST: begin
        if (cnt_reg == BURST_LAST) begin
          state_next = ECHO;
          cnt_next   = 24'd0;
        end else begin
          cnt_next = cnt_reg + 24'd1;
        end
      end
      ECHO: begin
        if (cnt_reg == width_q_reg - 24'd1) begin
          state_next = HOLDOFF;
          cnt_next   = 24'd0;
        end else begin
          cnt_next = cnt_reg + 24'd1;
        end
      end
      HOLDOFF: begin
        if (cnt_reg == HOLDOFF_LAST) begin
          state_next = IDLE;
          cnt_next   = 24'd0;
        end else begin
          cnt_next = cnt_reg + 24'd1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, counters, distance latch and registered outputs. width_q follows
  // dist_q one cycle later, which is always before ECHO starts because BURST
  // lasts at least one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      trig_cnt_reg   <= 24'd0;
      cnt_reg        <= 24'd0;
      dist_q_reg     <= 8'd0;
      width_q_reg    <= 24'd0;
      echo_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      short_trig_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      trig_cnt_reg   <= trig_cnt_next;
      cnt_reg        <= cnt_next;
      width_q_reg    <= width_calc;
      echo_reg       <= (state_next == ECHO);
      busy_reg       <= (state_next != IDLE);
      short_trig_reg <= short_trig_next;
      if (dist_latch) begin
        dist_q_reg <= bus.distance_cm;
      end
    end
  end

  assign bus.echo       = echo_reg;
  assign bus.busy       = busy_reg;
  assign bus.short_trig = short_trig_reg;

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// Directed bench for ultrasonic_echo_responder with small timing parameters.
// Expected widths follow ECHO_MAX_RANGE_EN when it is defined for the build.
module tb_ultrasonic_echo_responder;

  localparam int TRIG_MIN = 5;
  localparam int BURST    = 4;
  localparam int CPC      = 3;
  localparam int MAXCM    = 20;
  localparam int TIMEOUT  = 100;
  localparam int HOLDOFF  = 10;

  // Pin fall -> echo rise: 2 synchroniser cycles + BURST + 1.
  localparam int EXP_RISE = 2 + BURST + 1;

`ifdef ECHO_MAX_RANGE_EN
  localparam int EXP_W50 = TIMEOUT;
  localparam int EXP_W0  = TIMEOUT;
  localparam int EXP_W21 = TIMEOUT;
`else
  localparam int EXP_W50 = 150;
  localparam int EXP_W0  = 3;
  localparam int EXP_W21 = 63;
`endif
  localparam int EXP_W20 = 60;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   short_cnt = 0;

  ultrasonic_echo_responder_if bus_if();

  ultrasonic_echo_responder #(
    .TRIG_MIN_CYCLES(TRIG_MIN),
    .BURST_CYCLES(BURST),
    .CYCLES_PER_CM(CPC),
    .MAX_CM(MAXCM),
    .TIMEOUT_CYCLES(TIMEOUT),
    .HOLDOFF_CYCLES(HOLDOFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if.slave)
  );

  always #5 clk = ~clk;

  // Count every short_trig pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus_if.short_trig === 1'b1) short_cnt++;
  end

  // Safety net against a hung DUT.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fire(input int high);
    bus_if.trig = 1'b1;
    tick(high);
    bus_if.trig = 1'b0;
  endtask

  // After trig pin falls: ticks until echo rises, echo width, ticks from
  // echo fall until busy drops. -1 marks an expired bound.
  task automatic measure(output int rise, output int width, output int hold);
    rise  = -1;
    width = -1;
    hold  = -1;
    for (int i = 1; i <= 400; i++) begin
      tick();
      if (bus_if.echo === 1'b1) begin
        rise = i;
        break;
      end
    end
    if (rise < 0) return;
    width = 1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (bus_if.echo === 1'b1) width++;
      else break;
    end
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (bus_if.busy === 1'b0) begin
        hold = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.trig = 1'b0;
    bus_if.distance_cm = 8'd0;
    tick(3);
    checks++;
    if (bus_if.echo !== 1'b0) begin
      errors++; $display("FAIL reset_echo: got %b expected 0", bus_if.echo);
    end
    checks++;
    if (bus_if.busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b expected 0", bus_if.busy);
    end
    checks++;
    if (bus_if.short_trig !== 1'b0) begin
      errors++; $display("FAIL reset_short_trig: got %b expected 0", bus_if.short_trig);
    end
    rst = 1'b0;
    tick(2);
    $display("reset: echo=%b busy=%b short_trig=%b", bus_if.echo, bus_if.busy, bus_if.short_trig);
  endtask

  task automatic test_basic();
    int rise, width, hold, s0;
    s0 = short_cnt;
    bus_if.distance_cm = 8'd7;
    bus_if.trig = 1'b1;
    tick(2);
    checks++;
    if (bus_if.busy !== 1'b0) begin
      errors++; $display("FAIL basic_busy_early: got %b expected 0", bus_if.busy);
    end
    tick(1);
    checks++;
    if (bus_if.busy !== 1'b1) begin
      errors++; $display("FAIL basic_busy_rise: got %b expected 1", bus_if.busy);
    end
    tick(3);
    bus_if.trig = 1'b0;
    measure(rise, width, hold);
    checks++;
    if (rise !== EXP_RISE) begin
      errors++; $display("FAIL basic_rise: got %0d expected %0d", rise, EXP_RISE);
    end
    checks++;
    if (width !== 21) begin
      errors++; $display("FAIL basic_width: got %0d expected 21", width);
    end
    checks++;
    if (hold !== HOLDOFF) begin
      errors++; $display("FAIL basic_holdoff: got %0d expected %0d", hold, HOLDOFF);
    end
    checks++;
    if (short_cnt - s0 !== 0) begin
      errors++; $display("FAIL basic_no_short: got %0d expected 0", short_cnt - s0);
    end
    $display("basic: dist=7 rise=%0d width=%0d holdoff=%0d", rise, width, hold);
  endtask

  task automatic test_short_trig();
    int widths[2] = '{3, 4};
    int rise, width, hold;
    foreach (widths[k]) begin
      int s0;
      bit echo_seen;
      s0 = short_cnt;
      echo_seen = 1'b0;
      fire(widths[k]);
      tick(2);
      checks++;
      if (bus_if.short_trig !== 1'b0) begin
        errors++; $display("FAIL short_early_%0d: got %b expected 0", widths[k], bus_if.short_trig);
      end
      tick(1);
      checks++;
      if (bus_if.short_trig !== 1'b1) begin
        errors++; $display("FAIL short_pulse_%0d: got %b expected 1", widths[k], bus_if.short_trig);
      end
      checks++;
      if (bus_if.busy !== 1'b0) begin
        errors++; $display("FAIL short_busy_%0d: got %b expected 0", widths[k], bus_if.busy);
      end
      for (int i = 0; i < 12; i++) begin
        tick();
        if (bus_if.echo !== 1'b0) echo_seen = 1'b1;
      end
      checks++;
      if (echo_seen !== 1'b0) begin
        errors++; $display("FAIL short_echo_%0d: got echo high expected none", widths[k]);
      end
      checks++;
      if (short_cnt - s0 !== 1) begin
        errors++; $display("FAIL short_count_%0d: got %0d expected 1", widths[k], short_cnt - s0);
      end
      $display("short: trig_high=%0d pulses=%0d echo_seen=%b", widths[k], short_cnt - s0, echo_seen);
    end
    // Exactly TRIG_MIN cycles is accepted.
    bus_if.distance_cm = 8'd1;
    fire(TRIG_MIN);
    measure(rise, width, hold);
    checks++;
    if (rise !== EXP_RISE || width !== 3) begin
      errors++; $display("FAIL min_trig: got rise=%0d width=%0d expected rise=%0d width=3", rise, width, EXP_RISE);
    end
    $display("short: trig_high=%0d rise=%0d width=%0d", TRIG_MIN, rise, width);
  endtask

  task automatic test_range();
    int dists[4] = '{50, 0, 20, 21};
    int exps[4];
    int rise, width, hold;
    exps = '{EXP_W50, EXP_W0, EXP_W20, EXP_W21};
    foreach (dists[k]) begin
      bus_if.distance_cm = 8'(dists[k]);
      fire(6);
      measure(rise, width, hold);
      checks++;
      if (width !== exps[k]) begin
        errors++; $display("FAIL range_width_%0d: got %0d expected %0d", dists[k], width, exps[k]);
      end
      checks++;
      if (rise !== EXP_RISE || hold !== HOLDOFF) begin
        errors++; $display("FAIL range_timing_%0d: got rise=%0d hold=%0d expected rise=%0d hold=%0d",
                           dists[k], rise, hold, EXP_RISE, HOLDOFF);
      end
      $display("range: dist=%0d width=%0d", dists[k], width);
    end
  endtask

  task automatic test_back_to_back();
    int rise, width, hold;
    bit spurious;
    bus_if.distance_cm = 8'd7;
    fire(6);
    tick(4);
    bus_if.distance_cm = 8'd15;   // BURST: already latched
    rise = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus_if.echo === 1'b1) begin
        rise = i;
        break;
      end
    end
    checks++;
    if (rise !== EXP_RISE - 4) begin
      errors++; $display("FAIL b2b_rise: got %0d expected %0d", rise, EXP_RISE - 4);
    end
    width = 1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus_if.echo === 1'b1) width++;
      else break;
    end
    checks++;
    if (width !== 21) begin
      errors++; $display("FAIL b2b_latched_width: got %0d expected 21", width);
    end
    // New trigger during HOLDOFF, held across HOLDOFF exit.
    tick(3);
    bus_if.trig = 1'b1;
    hold = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus_if.busy === 1'b0) begin
        hold = i;
        break;
      end
    end
    checks++;
    if (hold !== HOLDOFF - 3) begin
      errors++; $display("FAIL b2b_holdoff: got %0d expected %0d", hold, HOLDOFF - 3);
    end
    spurious = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus_if.busy !== 1'b0 || bus_if.echo !== 1'b0) spurious = 1'b1;
    end
    bus_if.trig = 1'b0;
    tick(4);
    if (bus_if.busy !== 1'b0) spurious = 1'b1;
    checks++;
    if (spurious !== 1'b0) begin
      errors++; $display("FAIL b2b_held_trig: got activity expected idle");
    end
    fire(6);
    measure(rise, width, hold);
    checks++;
    if (rise !== EXP_RISE || width !== 45 || hold !== HOLDOFF) begin
      errors++; $display("FAIL b2b_second: got rise=%0d width=%0d hold=%0d expected %0d 45 %0d",
                         rise, width, hold, EXP_RISE, HOLDOFF);
    end
    $display("b2b: second measurement dist=15 width=%0d", width);
  endtask

  task automatic test_reset_mid_echo();
    int rise, width, hold;
    bit found;
    bus_if.distance_cm = 8'd7;
    fire(6);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus_if.echo === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    tick(7);
    checks++;
    if (found !== 1'b1 || bus_if.echo !== 1'b1) begin
      errors++; $display("FAIL midrst_echo_before: got found=%b echo=%b expected 1 1", found, bus_if.echo);
    end
    rst = 1'b1;
    tick(1);
    checks++;
    if (bus_if.echo !== 1'b0) begin
      errors++; $display("FAIL midrst_echo: got %b expected 0", bus_if.echo);
    end
    checks++;
    if (bus_if.busy !== 1'b0) begin
      errors++; $display("FAIL midrst_busy: got %b expected 0", bus_if.busy);
    end
    rst = 1'b0;
    tick(2);
    fire(6);
    measure(rise, width, hold);
    checks++;
    if (rise !== EXP_RISE || width !== 21 || hold !== HOLDOFF) begin
      errors++; $display("FAIL midrst_after: got rise=%0d width=%0d hold=%0d expected %0d 21 %0d",
                         rise, width, hold, EXP_RISE, HOLDOFF);
    end
    $display("midrst: post-reset width=%0d", width);
  endtask

  initial begin
    rst = 1'b1;
    bus_if.trig = 1'b0;
    bus_if.distance_cm = 8'd0;
    test_reset();
    test_basic();
    test_short_trig();
    test_range();
    test_back_to_back();
    test_reset_mid_echo();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ultrasonic_echo_responder.md
# ultrasonic_echo_responder

- Emulates the HC-SR04 ultrasonic ranging module from the sensor's side of the trigger/echo protocol.
- Accepts a trigger pulse and answers with an echo pulse whose width encodes a programmed distance in centimetres.
- Sits in place of the physical sensor, on the FPGA or in simulation, so the distance-measurement chain (trigger generation, echo timing, too-close decision) runs closed-loop without hardware.

## Interface
Parameters:
- TRIG_MIN_CYCLES, 500, minimum trigger high width accepted (10 us @ 50 MHz)
- BURST_CYCLES, 10000, delay from trigger fall to echo rise (200 us, emulates 8-cycle 40 kHz burst)
- CYCLES_PER_CM, 2900, echo cycles per cm (58 us/cm @ 50 MHz)
- MAX_CM, 200, largest in-range distance
- TIMEOUT_CYCLES, 1900000, no-object echo width (38 ms)
- HOLDOFF_CYCLES, 500000, dead time after echo falls (10 ms)

Ports:
- clk  in  1  system clock (50 MHz); all logic on rising edge
- rst  in  1  synchronous, active-high reset
- trig  in  1  trigger from the sensor driver; asynchronous; synchronised internally
- distance_cm  in  8  emulated target distance; sampled once per measurement
- echo  out  1  echo pulse to the sensor driver
- busy  out  1  high whenever state is not IDLE
- short_trig  out  1  one-cycle pulse when a trigger shorter than TRIG_MIN_CYCLES is rejected

## Operation
- trig passes through a 2-flop synchroniser to give trig_s. A rising edge is trig_s low in the previous cycle and high in the current cycle.
- States: IDLE, TRIG_HIGH, BURST, ECHO, HOLDOFF. The sequence below is the state machine's complete transition set.
  - IDLE: on a trig_s rising edge, go to TRIG_HIGH with trig_cnt=1.
  - TRIG_HIGH, trig_s high: trig_cnt increments, saturating at TRIG_MIN_CYCLES.
  - TRIG_HIGH, trig_s low with trig_cnt >= TRIG_MIN_CYCLES: go to BURST, latch distance_cm into dist_q, register width_q = max(dist_q,1) * CYCLES_PER_CM.
  - TRIG_HIGH, trig_s low with trig_cnt < TRIG_MIN_CYCLES: go to IDLE and pulse short_trig for 1 cycle.
  - BURST: runs exactly BURST_CYCLES cycles, then go to ECHO.
  - ECHO: echo is high for exactly width_q cycles, then go to HOLDOFF.
  - HOLDOFF: echo is low for exactly HOLDOFF_CYCLES cycles and trig is ignored, then go to IDLE.
- Leaving HOLDOFF with trig still high does not start a measurement; a fresh rising edge is required.
- distance_cm changes after the latch point have no effect until the next measurement.
- Arithmetic:
  - Counters are 24 bits wide; all parameter values must be < 2^24.
  - width_q is 24 bits; 255 * 2900 = 739500 fits.
  - dist_q = 0 is treated as 1 cm.
- Reset:
  - rst has priority over every event.
  - Next cycle: state IDLE, echo=0, busy=0, short_trig=0, counters and synchroniser cleared.
  - Holds mid-echo as well: echo drops on the cycle after rst is sampled high.

## Timing
- Reset values: echo=0, busy=0, short_trig=0.
- trig pin to trig_s: 2 cycles.
- trig_s fall (valid trigger) to echo rise: BURST_CYCLES+1 cycles; the transition cycle into BURST counts as the first cycle of no echo.
- echo width: exactly width_q cycles, or TIMEOUT_CYCLES in the no-object case (see Configuration).
- Minimum period between echo falls: HOLDOFF_CYCLES + TRIG_MIN_CYCLES + BURST_CYCLES + width + synchroniser delay.
- busy rises the cycle after the rising edge is detected and falls on HOLDOFF exit.
- short_trig is asserted on the cycle the state returns to IDLE.

## Configuration
- ECHO_MAX_RANGE_EN defined:
  - dist_q > MAX_CM or dist_q = 0 is treated as no object.
  - width_q = TIMEOUT_CYCLES in that case.
- ECHO_MAX_RANGE_EN undefined:
  - width_q is always max(dist_q,1) * CYCLES_PER_CM; no range check or timeout logic is built.

## Test plan
Bench parameters: TRIG_MIN_CYCLES=5, BURST_CYCLES=4, CYCLES_PER_CM=3, MAX_CM=20, TIMEOUT_CYCLES=100, HOLDOFF_CYCLES=10.
- distance_cm=7, trig high 6 cycles -> echo rises 5 cycles after trig_s falls; echo high exactly 21 cycles; busy low 10 cycles after echo falls.
- trig high 3 cycles -> short_trig pulses once, echo stays 0, busy returns 0.
- ECHO_MAX_RANGE_EN defined, distance_cm=50 -> echo width 100 cycles. ECHO_MAX_RANGE_EN undefined, distance_cm=50 -> echo width 150 cycles.
- distance_cm=0 -> ECHO_MAX_RANGE_EN undefined: echo width 3 cycles. ECHO_MAX_RANGE_EN defined: 100 cycles.
- Change distance_cm from 7 to 15 during BURST, then issue a new trigger during HOLDOFF held through HOLDOFF exit -> first echo is 21 cycles; no second measurement occurs until trig goes low then high.
- rst asserted 8 cycles into ECHO -> echo=0 and busy=0 on the next cycle; the next valid trigger produces a normal full-width echo.
